bram_tile_reader: RTL and testbench
===================================

# bram_tile_reader

Read-side address generator and stream formatter for the activation/weight BRAM. On `start` it walks a 2-D tile of 32-bit words (rows × words-per-row, arbitrary row stride), drives the BRAM byte read address and absorbs its 1-cycle read latency. Words are handed to the downstream compute stage over a valid/ready stream with row and tile markers. Sits directly downstream of the BRAM, between it and the convolution datapath.

## Interface
- `ADDR_W`, 20, byte-address width (matches BRAM `rd_addr`)
- `DATA_W`, 32, word width (matches BRAM `data_out`)
- `CNT_W`, 8, width of row/column counters
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  begin a tile; sampled only in IDLE
- `base_addr`  in  ADDR_W  byte address of word (0,0); low 2 bits ignored (forced 0)
- `row_stride`  in  ADDR_W  byte distance between row starts; low 2 bits ignored
- `num_rows`  in  CNT_W  rows in tile
- `num_cols`  in  CNT_W  words per row
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at tile completion
- `rd_addr`  out  ADDR_W  byte address to BRAM
- `bram_data`  in  DATA_W  BRAM `data_out`, valid one cycle after `rd_addr`
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_W  output word
- `m_row_last`  out  1  word is last of its row
- `m_last`  out  1  word is last of tile

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches all config inputs; if `num_rows`==0 or `num_cols`==0 go to DONE (no reads, no beats), else RUN.
- RUN: issue one read per cycle while `(fifo_count + inflight) < 2`. Address = `row_base + 4*col`; after col `num_cols-1`, col←0, `row_base += row_stride`, row++. After issuing (rows-1, cols-1) go to DRAIN.
- Address arithmetic modulo 2^ADDR_W (wrap silently, no error).
- Each issued read sets a 1-bit `inflight` tag; next cycle `bram_data` plus its row_last/last tags are pushed into a 2-entry output FIFO.
- DRAIN: wait until FIFO empty and no read in flight, then DONE.
- DONE: `done`=1 for one cycle, `busy`=0 in the same cycle, return to IDLE.
- `start` while not IDLE is ignored; config inputs ignored outside the IDLE sample.
- Reads are not issued when no credit is available; `rd_addr` holds last value (stray BRAM reads are harmless and discarded).
- No BRAM writes are permitted while `busy`; BRAM returns 0 during writes and that data would be forwarded unchanged (system-level rule, not checked).
- Reset: all state cleared, in-flight read discarded, FIFO emptied.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_addr`=0, `m_valid`=0, `m_data`=0, `m_row_last`=0, `m_last`=0.
- `start` sampled at edge T; first `rd_addr` driven in cycle T+1; data captured at end of T+2; first `m_valid` in cycle T+3.
- With `m_ready` held high: one beat per cycle, no bubbles; N-word tile gives last beat at T+2+N, `done` in cycle T+3+N.
- Stream rules: `m_data`/tags stable while `m_valid`=1 and `m_ready`=0; `m_valid` never drops without handshake.
- Simultaneous push and pop on full FIFO is legal; count unchanged.
- `done` never coincides with `m_valid`=1.

## Structure
- Shared package `bram_rd_pkg`: `ADDR_W`/`DATA_W`/`CNT_W` defaults, state enum (IDLE, RUN, DRAIN, DONE), byte-per-word constant 4.
- Sub-module `bram_rd_skid`: 2-entry FIFO of {data, row_last, last} with push/pop/count; top holds FSM, counters, credit logic.

## Test plan
- base 0x100, stride 0x40, 2 rows × 3 cols, `m_ready`=1 -> `rd_addr` 0x100,0x104,0x108,0x140,0x144,0x148; `m_row_last` on beats 3,6; `m_last` on beat 6; `done` 3+6 cycles after `start`.
- Same tile, `m_ready` random 50% -> exactly 6 beats, order/data match BRAM model, no duplicates, data stable under stall.
- `num_rows`=0 (and separately `num_cols`=0) -> `done` pulses, zero `m_valid` beats, `busy` ≤ 1 cycle.
- base 0xFFFFC, stride 0, 1 row × 2 cols -> `rd_addr` 0xFFFFC then 0x00000.
- `start` pulsed mid-RUN with different config -> ignored; original tile completes unchanged.
- `rst_n` asserted during RUN with a read in flight -> all outputs at reset values immediately; next `start` runs a clean tile.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// Shared defaults, FSM encoding and word geometry for the BRAM tile reader.
package bram_rd_pkg;

    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_CNT_W      = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry output FIFO of {data, row_last, last}; head entry is held in a
// register so the stream outputs come straight from flops.
module bram_rd_skid
    import bram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_row_last,
    input  logic              push_last,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row_last,
    output logic              out_last,
    output logic [1:0]        count
);

    localparam int ENT_W = DATA_W + 2;

    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] tail_r;
    logic [ENT_W-1:0] head_n;
    logic [ENT_W-1:0] tail_n;
    logic [ENT_W-1:0] push_ent_s;
    logic [1:0]       count_r;
    logic [1:0]       count_n;
    logic             valid_r;

    assign push_ent_s = {push_data, push_row_last, push_last};

    // Next-state of the head/tail pair; a pop promotes the tail into the head.
    always_comb begin
        head_n  = head_r;
        tail_n  = tail_r;
        count_n = count_r;
        case (count_r)
            2'd0: begin
                if (push) begin
                    head_n  = push_ent_s;
                    count_n = 2'd1;
                end else begin
                    count_n = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_n = push_ent_s;
                end else if (push) begin
                    tail_n  = push_ent_s;
                    count_n = 2'd2;
                end else if (pop) begin
                    count_n = 2'd0;
                end else begin
                    count_n = 2'd1;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_n = tail_r;
                    if (push) begin
                        tail_n = push_ent_s;
                    end else begin
                        count_n = 2'd1;
                    end
                end else begin
                    count_n = 2'd2;
                end
            end
            default: begin
                count_n = 2'd0;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_n;
            tail_r  <= tail_n;
            count_r <= count_n;
            valid_r <= (count_n != 2'd0);
        end
    end

    assign out_valid    = valid_r;
    assign out_data     = head_r[ENT_W-1:2];
    assign out_row_last = head_r[1];
    assign out_last     = head_r[0];
    assign count        = count_r;

endmodule

// File: rtl/bram_tile_reader.sv
// Walks a rows x cols tile of 32-bit words in BRAM, absorbs the 1-cycle read
// latency and streams the words out with row/tile markers.
module bram_tile_reader
    import bram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [CNT_W-1:0]  num_cols,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_row_last,
    output logic              m_last
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);

    state_e            state_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] stride_r;
    logic [CNT_W-1:0]  rows_r;
    logic [CNT_W-1:0]  cols_r;
    logic [CNT_W-1:0]  row_r;
    logic [CNT_W-1:0]  col_r;
    logic              inflight_r;
    logic              infl_row_last_r;
    logic              infl_last_r;

    logic [1:0]        fifo_count_s;
    logic [2:0]        credit_use_s;
    logic              pop_s;
    logic              issue_s;
    logic              col_end_s;
    logic              row_end_s;
    logic              drain_ok_s;

    // Credit check (a beat leaving this cycle frees its slot), position flags, drain exit.
    always_comb begin
        pop_s        = m_valid & m_ready;
        col_end_s    = (col_r == (cols_r - CNT_W'(1)));
        row_end_s    = (row_r == (rows_r - CNT_W'(1)));
        credit_use_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
        if (state_r == ST_RUN) begin
            issue_s = (credit_use_s < (3'd2 + {2'b00, pop_s}));
        end else begin
            issue_s = 1'b0;
        end
        if (inflight_r) begin
            drain_ok_s = 1'b0;
        end else if (fifo_count_s == 2'd0) begin
            drain_ok_s = 1'b1;
        end else begin
            drain_ok_s = (fifo_count_s == 2'd1) && pop_s;
        end
    end

    // Read-latency stage: tags travel with the read until its data is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r      <= 1'b0;
            infl_row_last_r <= 1'b0;
            infl_last_r     <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            infl_row_last_r <= col_end_s;
            infl_last_r     <= col_end_s & row_end_s;
        end
    end

    // Tile-walk FSM with address counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            row_base_r <= '0;
            stride_r   <= '0;
            rows_r     <= '0;
            cols_r     <= '0;
            row_r      <= '0;
            col_r      <= '0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_r     <= num_rows;
                        cols_r     <= num_cols;
                        stride_r   <= row_stride & WORD_MASK;
                        row_base_r <= base_addr & WORD_MASK;
                        row_r      <= '0;
                        col_r      <= '0;
                        if ((num_rows == '0) || (num_cols == '0)) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy    <= 1'b1;
                            rd_addr <= base_addr & WORD_MASK;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (col_end_s) begin
                            col_r <= '0;
                            if (row_end_s) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                row_r      <= row_r + CNT_W'(1);
                                row_base_r <= row_base_r + stride_r;
                                rd_addr    <= row_base_r + stride_r;
                            end
                        end else begin
                            col_r   <= col_r + CNT_W'(1);
                            rd_addr <= rd_addr + WORD_STEP;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ok_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    bram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (inflight_r),
        .push_data     (bram_data),
        .push_row_last (infl_row_last_r),
        .push_last     (infl_last_r),
        .pop           (pop_s),
        .out_valid     (m_valid),
        .out_data      (m_data),
        .out_row_last  (m_row_last),
        .out_last      (m_last),
        .count         (fifo_count_s)
    );

endmodule

// File: tb/tb_bram_tile_reader.sv
// Scoreboard bench for bram_tile_reader: stimulus queues expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_bram_tile_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] row_stride;
    logic [7:0]  num_rows;
    logic [7:0]  num_cols;
    logic        busy;
    logic        done;
    logic [19:0] rd_addr;
    logic [31:0] bram_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_row_last;
    logic        m_last;

    int          checks = 0;
    int          passes = 0;
    bit          rand_mode = 1'b0;
    logic [33:0] exp_q[$];
    bit          hold_vld = 1'b0;
    logic [33:0] hold_ent;
    logic [19:0] addr_a [8];
    logic [19:0] addr_w [8];
    logic [19:0] addr_z [8];

    bram_tile_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .bram_data  (bram_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row_last (m_row_last),
        .m_last     (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bram_word(input logic [19:0] a);
        return {12'hC3A, a};
    endfunction

    // BRAM model: one-cycle registered read of an address-derived word.
    always @(posedge clk) bram_data <= bram_word(rd_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: compare each accepted beat with the queue head; check stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", m_data, hold_ent[33:2]);
                check("stall_tags", {30'd0, m_row_last, m_last}, {30'd0, hold_ent[1:0]});
            end
            if (m_valid && m_ready) begin
                hold_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_beat: got beat 0x%0h, expected no beat", m_data);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e[33:2]);
                    check("beat_tags", {30'd0, m_row_last, m_last}, {30'd0, e[1:0]});
                end
            end else if (m_valid) begin
                hold_vld = 1'b1;
                hold_ent = {m_data, m_row_last, m_last};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_done", tag), 32'(done), 32'd0);
        check($sformatf("%s_rd_addr", tag), 32'(rd_addr), 32'd0);
        check($sformatf("%s_m_valid", tag), 32'(m_valid), 32'd0);
        check($sformatf("%s_m_data", tag), m_data, 32'd0);
        check($sformatf("%s_m_row_last", tag), 32'(m_row_last), 32'd0);
        check($sformatf("%s_m_last", tag), 32'(m_last), 32'd0);
    endtask

    task automatic run_tile(input string tag, input logic [19:0] base, input logic [19:0] stride,
                            input logic [7:0] rows, input logic [7:0] cols, input int n,
                            input logic [19:0] addrs [8], input bit chk_timing, input int glitch_at);
        int  k;
        int  busy_cycles;
        bit  seen;
        for (int i = 0; i < n; i++) begin
            logic rl;
            logic ll;
            rl = (((i + 1) % int'(cols)) == 0);
            ll = (i == n - 1);
            exp_q.push_back({bram_word(addrs[i]), rl, ll});
        end
        @(negedge clk);
        base_addr  = base;
        row_stride = stride;
        num_rows   = rows;
        num_cols   = cols;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            k++;
            @(negedge clk);
            if (glitch_at == k) begin
                start      = 1'b1;
                base_addr  = 20'h00800;
                row_stride = 20'h00000;
                num_rows   = 8'd1;
                num_cols   = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cycles++;
            if (k == 1) check($sformatf("%s_busy_first", tag), 32'(busy), (n > 0) ? 32'd1 : 32'd0);
            if (chk_timing && k <= n)
                check($sformatf("%s_rd_addr%0d", tag, k), 32'(rd_addr), 32'(addrs[k-1]));
            if (done) begin
                seen = 1'b1;
                check($sformatf("%s_done_busy", tag), 32'(busy), 32'd0);
                check($sformatf("%s_done_valid", tag), 32'(m_valid), 32'd0);
                if (chk_timing)
                    check($sformatf("%s_done_cycle", tag), 32'(k), (n == 0) ? 32'd1 : 32'(n + 3));
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", tag, k);
        end
        if (n == 0) check($sformatf("%s_busy_le1", tag), 32'(busy_cycles <= 1), 32'd1);
        else if (chk_timing) check($sformatf("%s_busy_cycles", tag), 32'(busy_cycles), 32'(n + 2));
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
        check($sformatf("%s_beats_left", tag), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        addr_a = '{20'h00100, 20'h00104, 20'h00108, 20'h00140, 20'h00144, 20'h00148, 20'h0, 20'h0};
        addr_w = '{20'hFFFFC, 20'h00000, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
        addr_z = '{20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = 20'h0;
        row_stride = 20'h0;
        num_rows   = 8'd0;
        num_cols   = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_tile("tileA", 20'h00100, 20'h00040, 8'd2, 8'd3, 6, addr_a, 1'b1, 0);

        rand_mode = 1'b1;
        run_tile("tileA_rand", 20'h00100, 20'h00040, 8'd2, 8'd3, 6, addr_a, 1'b0, 0);
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

        run_tile("rows0", 20'h00100, 20'h00040, 8'd0, 8'd3, 0, addr_z, 1'b1, 0);
        run_tile("cols0", 20'h00100, 20'h00040, 8'd2, 8'd0, 0, addr_z, 1'b1, 0);
        run_tile("wrap", 20'hFFFFC, 20'h00000, 8'd1, 8'd2, 2, addr_w, 1'b1, 0);
        run_tile("glitch", 20'h00100, 20'h00040, 8'd2, 8'd3, 6, addr_a, 1'b1, 2);

        // Reset with a read in flight, then a clean tile.
        @(negedge clk);
        base_addr  = 20'h00100;
        row_stride = 20'h00040;
        num_rows   = 8'd2;
        num_cols   = 8'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_tile("after_rst", 20'h00100, 20'h00040, 8'd2, 8'd3, 6, addr_a, 1'b1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
